noc_vc_arb_merge: RTL

NOC_VC_ARB_MERGE -- requirements
Module: noc_vc_arb_merge

---
 rtl/noc_vc_arb_merge_pkg.sv | 13 +
 rtl/noc_vc_arb_merge_rr_arbiter.sv | 45 ++++
 rtl/noc_vc_arb_merge.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/noc_vc_arb_merge_pkg.sv
// Shared NoC parameters and the wormhole lock state type for the VC merge block.
package Noc_parameters;

   localparam int unsigned Noc_VC_Channel    = 4;
   localparam int unsigned Noc_Data_Width    = 32;
   localparam int unsigned Noc_VC_Fifo_Depth = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } noc_vc_lock_state_e;

endpackage

// File: rtl/noc_vc_arb_merge_rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last one
// that was advanced past. The pointer moves only on the advance strobe.
module noc_rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] idx;
   logic          found;

   // First requester at or after the pointer, wrapping modulo N
   always_comb begin
      grant   = '0;
      gnt_idx = ptr;
      idx     = ptr;
      found   = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         idx = PW'((int'(ptr) + k) % int'(N));
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gnt_idx    = idx;
            found      = 1'b1;
         end
      end
   end

   // Pointer moves to the slot after the current winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

endmodule

// File: rtl/noc_vc_arb_merge.sv
// Virtual-channel merge: round-robin arbitration with wormhole locking into a
// first-word-fall-through FIFO. Optional per-VC flit counters are built when
// NOC_VC_MERGE_STATS_EN is defined.
module noc_vc_arb_merge
   import Noc_parameters::*;
#(
   parameter int unsigned CHANNELS   = Noc_VC_Channel,
   parameter int unsigned DATA_WIDTH = Noc_Data_Width,
   parameter int unsigned DEPTH      = Noc_VC_Fifo_Depth,
   parameter int unsigned THRESHOLD  = DEPTH - 2
) (
   input  logic                           noc_clk,
   input  logic                           noc_rst,
   input  logic [CHANNELS-1:0]            i_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_flit,
   input  logic [CHANNELS-1:0]            i_tail,
   output logic [CHANNELS-1:0]            o_ready,
   output logic                           o_vc_ready,
   output logic                           o_valid,
   output logic [DATA_WIDTH-1:0]          o_flit,
   output logic [$clog2(CHANNELS)-1:0]    o_vc_id,
   output logic                           o_tail,
   input  logic                           i_ready
`ifdef NOC_VC_MERGE_STATS_EN
   ,
   output logic [CHANNELS*32-1:0]         o_flit_cnt
`endif
);

   localparam int unsigned VW = $clog2(CHANNELS);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = DATA_WIDTH + VW + 1;

   noc_vc_lock_state_e    state, state_n;
   logic [VW-1:0]         lock_vc, lock_vc_n;
   logic [CHANNELS-1:0]   arb_req;
   logic [CHANNELS-1:0]   grant;
   logic [VW-1:0]         gnt_idx;
   logic [DATA_WIDTH-1:0] sel_flit;
   logic                  sel_tail;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [EW-1:0]         mem [DEPTH];

   // While locked only the owning VC is offered to the arbiter, valid or not
   assign arb_req = (state == LOCK) ? (CHANNELS'(1) << lock_vc) : i_valid;

   noc_rr_arbiter #(
      .N (CHANNELS)
   ) u_arb (
      .clk     (noc_clk),
      .rst     (noc_rst),
      .req     (arb_req),
      .advance (push && sel_tail),
      .grant   (grant)
   );

   // Encode the one-hot grant and select the granted VC's flit
   always_comb begin
      gnt_idx  = '0;
      sel_flit = '0;
      sel_tail = 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         if (grant[c]) begin
            gnt_idx  = VW'(c);
            sel_flit = i_flit[c*DATA_WIDTH +: DATA_WIDTH];
            sel_tail = i_tail[c];
         end
      end
   end

   // A full FIFO still accepts when the head is popped in the same cycle
   assign full     = (count == CW'(DEPTH));
   assign o_ready  = (!noc_rst && (!full || i_ready)) ? grant : '0;
   assign push     = |(i_valid & o_ready);
   assign pop      = o_valid && i_ready;

   // Wormhole lock next-state logic
   always_comb begin
      state_n   = state;
      lock_vc_n = lock_vc;
      case (state)
         IDLE: begin
            if (push && !sel_tail) begin
               state_n   = LOCK;
               lock_vc_n = gnt_idx;
            end
         end
         LOCK: begin
            if (push && sel_tail) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Lock state register
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         state   <= IDLE;
         lock_vc <= '0;
      end else begin
         state   <= state_n;
         lock_vc <= lock_vc_n;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage, intentionally not reset
   always_ff @(posedge noc_clk) begin
      if (push) mem[wr_ptr] <= {sel_flit, gnt_idx, sel_tail};
   end

   assign {o_flit, o_vc_id, o_tail} = mem[rd_ptr];
   assign o_valid    = (count != '0);
   assign o_vc_ready = (count < CW'(THRESHOLD));

`ifdef NOC_VC_MERGE_STATS_EN
   // Saturating per-VC accepted-flit counters
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         o_flit_cnt <= '0;
      end else begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            if (push && grant[c] && (o_flit_cnt[c*32 +: 32] != 32'hFFFF_FFFF))
               o_flit_cnt[c*32 +: 32] <= o_flit_cnt[c*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule
